// File: rtl/ysyx_22050598_cache_lru_table.sv
// True-LRU replacement table: one ordered recency list per set (pos 0 = MRU, pos WAYS-1 = LRU),
// with touch/demote updates, registered victim lookup and a one-set-per-cycle flush sequencer.
module ysyx_22050598_cache_lru_table #(
  parameter int WAYS = 4,
  parameter int SETS = 16,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             touch_vld,
  input  logic [SET_W-1:0] touch_set,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             demote_vld,
  input  logic [SET_W-1:0] demote_set,
  input  logic [WAY_W-1:0] demote_way,
  input  logic             victim_req,
  input  logic [SET_W-1:0] victim_set,
  output logic             victim_vld,
  output logic [WAY_W-1:0] victim_way,
  input  logic             flush_req,
  output logic             busy
);

  typedef logic [WAYS-1:0][WAY_W-1:0] list_t;
  typedef enum logic {IDLE, FLUSH} state_t;

  list_t            lru_q [SETS];
  state_t           state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  list_t            touch_list, demote_list;
  logic             touch_en, demote_en, victim_en;

  function automatic list_t reset_list();
    list_t r;
    for (int p = 0; p < WAYS; p++) r[p] = WAY_W'(p);
    return r;
  endfunction

  // Entries above the touched way's position slide down by one; the rest stay.
  function automatic list_t promote(input list_t l, input logic [WAY_W-1:0] w);
    list_t r;
    logic  seen;
    seen = 1'b0;
    r[0] = w;
    for (int p = 1; p < WAYS; p++) begin
      seen = seen | (l[p-1] == w);
      r[p] = seen ? l[p] : l[p-1];
    end
    return r;
  endfunction

  function automatic list_t demote(input list_t l, input logic [WAY_W-1:0] w);
    list_t r;
    logic  seen;
    seen = 1'b0;
    r[WAYS-1] = w;
    for (int p = 0; p < WAYS - 1; p++) begin
      seen = seen | (l[p] == w);
      r[p] = seen ? l[p+1] : l[p];
    end
    return r;
  endfunction

  assign busy      = (state_q == FLUSH);
  assign touch_en  = touch_vld & ~busy;
  // A same-set demote loses to the touch so the list stays a single consistent update.
  assign demote_en = demote_vld & ~busy & ~(touch_en && (touch_set == demote_set));
  assign victim_en = victim_req & ~busy;

  always_comb begin
    touch_list  = promote(lru_q[touch_set], touch_way);
    demote_list = demote(lru_q[demote_set], demote_way);
  end

  // NOTE: the table is plain flops, so it is reset with the rest; a RAM here could not be.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) lru_q[s] <= reset_list();
    end else begin
      for (int s = 0; s < SETS; s++) begin
        if (busy && cnt_q == SET_W'(s))
          lru_q[s] <= reset_list();
        else if (touch_en && touch_set == SET_W'(s))
          lru_q[s] <= touch_list;
        else if (demote_en && demote_set == SET_W'(s))
          lru_q[s] <= demote_list;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      victim_vld <= 1'b0;
      victim_way <= '0;
    end else begin
      victim_vld <= victim_en;
      if (victim_en) victim_way <= lru_q[victim_set][WAYS-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SET_W'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22050598_cache_lru_table.sv
// Scoreboard bench for the LRU table: stimulus pushes expected victims, a monitor pops on victim_vld.
module tb_ysyx_22050598_cache_lru_table;
  localparam int WAYS = 4;
  localparam int SETS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       touch_vld = 1'b0, demote_vld = 1'b0, victim_req = 1'b0, flush_req = 1'b0;
  logic [3:0] touch_set = '0, demote_set = '0, victim_set = '0;
  logic [1:0] touch_way = '0, demote_way = '0;
  logic       victim_vld, busy;
  logic [1:0] victim_way;

  int checks = 0;
  int passed = 0;
  logic [1:0] exp_q[$];

  ysyx_22050598_cache_lru_table #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst),
    .touch_vld(touch_vld), .touch_set(touch_set), .touch_way(touch_way),
    .demote_vld(demote_vld), .demote_set(demote_set), .demote_way(demote_way),
    .victim_req(victim_req), .victim_set(victim_set),
    .victim_vld(victim_vld), .victim_way(victim_way),
    .flush_req(flush_req), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // Monitor: every victim_vld pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && victim_vld) begin
      if (exp_q.size() == 0) check("unexpected victim_vld", 1, 0);
      else check("victim_way", int'(victim_way), int'(exp_q.pop_front()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic touch(input int s, input int w);
    touch_vld = 1'b1; touch_set = 4'(s); touch_way = 2'(w);
    cyc();
    touch_vld = 1'b0;
  endtask

  task automatic demote(input int s, input int w);
    demote_vld = 1'b1; demote_set = 4'(s); demote_way = 2'(w);
    cyc();
    demote_vld = 1'b0;
  endtask

  task automatic victim(input int s, input int e);
    victim_req = 1'b1; victim_set = 4'(s);
    exp_q.push_back(2'(e));
    cyc();
    victim_req = 1'b0;
  endtask

  task automatic all_victims_three();
    for (int s = 0; s < SETS; s++) victim(s, 3);
  endtask

  int busy_cycles;

  initial begin
    #12;
    check("reset busy", int'(busy), 0);
    check("reset victim_vld", int'(victim_vld), 0);
    check("reset victim_way", int'(victim_way), 0);
    @(negedge clk);
    rst = 1'b1;
    cyc();

    // 1: reset ordering
    victim(5, 3); victim(0, 3); victim(15, 3);

    // 2: set 2 touches
    touch(2, 3); touch(2, 2); touch(2, 1);
    victim(2, 0);
    touch(2, 0);
    victim(2, 3);

    // 3: set 7 reversal and demotes
    touch(7, 0); touch(7, 1); touch(7, 2); touch(7, 3);
    victim(7, 0);
    demote(7, 2);
    victim(7, 2);
    demote(7, 2);
    victim(7, 2);
    touch(7, 0);          // [0,3,1,2] -> LRU still 2
    victim(7, 2);

    // 4: same-set collision drops the demote; different sets both apply
    touch_vld = 1'b1; touch_set = 4'd4; touch_way = 2'd3;
    demote_vld = 1'b1; demote_set = 4'd4; demote_way = 2'd0;
    cyc();
    touch_vld = 1'b0; demote_vld = 1'b0;
    victim(4, 2);
    demote(4, 1);         // [3,0,1,2] -> [3,0,2,1]
    victim(4, 1);
    touch_vld = 1'b1; touch_set = 4'd4; touch_way = 2'd3;
    demote_vld = 1'b1; demote_set = 4'd9; demote_way = 2'd0;
    cyc();
    touch_vld = 1'b0; demote_vld = 1'b0;
    victim(9, 0);
    victim(4, 1);

    // 5: read-old victim alongside a touch of the same set
    touch_vld = 1'b1; touch_set = 4'd1; touch_way = 2'd3;
    victim_req = 1'b1; victim_set = 4'd1;
    exp_q.push_back(2'd3);
    cyc();
    touch_vld = 1'b0; victim_req = 1'b0;
    victim(1, 2);

    // 6: flush
    touch(0, 3); touch(8, 3); demote(15, 0);
    victim(15, 0);
    cyc();
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    check("busy after flush_req", int'(busy), 1);
    busy_cycles = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cycles++;
      touch_vld = 1'b1; touch_set = 4'(i); touch_way = 2'd3;
      victim_req = 1'b1; victim_set = 4'(i);
      flush_req = 1'b1;
      cyc();
    end
    touch_vld = 1'b0; victim_req = 1'b0; flush_req = 1'b0;
    check("busy cycle count", busy_cycles, SETS);
    cyc();
    check("victim_vld after busy requests", int'(victim_vld), 0);
    all_victims_three();

    // 6b: reset in the middle of a flush
    touch(3, 3); touch(12, 3);
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    repeat (6) cyc();
    check("busy mid-flush", int'(busy), 1);
    rst = 1'b0;
    #1;
    check("busy after async reset", int'(busy), 0);
    check("victim_vld after async reset", int'(victim_vld), 0);
    cyc();
    rst = 1'b1;
    cyc();
    check("busy after reset release", int'(busy), 0);
    all_victims_three();

    repeat (3) cyc();
    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
